// File: rtl/univ_shift_reg.sv
// Universal shift register: parallel load, single-step shifts/rotates and
// counted burst shifts driven by a small IDLE/RUN/DONE controller.
module univ_shift_reg #(
  parameter int WIDTH = 16,
  parameter int CNT_W = 5
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [WIDTH-1:0] in,
  input  logic             ld,
  input  logic             shift,
  input  logic [2:0]       mode,
  input  logic             serial_in,
  input  logic             start,
  input  logic [CNT_W-1:0] count,
  output logic [WIDTH-1:0] out,
  output logic             serial_out,
  output logic             busy,
  output logic             done
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t           state_r, state_s;
  logic [WIDTH-1:0] out_r, out_s;
  logic             sout_r, sout_s;
  logic [CNT_W-1:0] rem_r, rem_s;
  logic [2:0]       mode_r, mode_s;
  logic [WIDTH:0]   step_s;
  logic             busy_s, done_s;

  // One shift step; result is {bit shifted out, new register value}.
  // Reserved modes return the inputs untouched so they act as hold.
  function automatic logic [WIDTH:0] shift_step(
    input logic [WIDTH-1:0] v,
    input logic [2:0]       m,
    input logic             si,
    input logic             so
  );
    case (m)
      3'b000:  shift_step = {v[0], si, v[WIDTH-1:1]};
      3'b001:  shift_step = {v[WIDTH-1], v[WIDTH-2:0], si};
      3'b010:  shift_step = {v[0], v[WIDTH-1], v[WIDTH-1:1]};
      3'b011:  shift_step = {v[0], v[0], v[WIDTH-1:1]};
      3'b100:  shift_step = {v[WIDTH-1], v[WIDTH-2:0], v[WIDTH-1]};
      default: shift_step = {so, v};
    endcase
  endfunction

  // State register.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_r <= IDLE;
    end else begin
      state_r <= state_s;
    end
  end

  // Next-state logic: IDLE arbitrates ld > start > shift.
  always_comb begin
    state_s = state_r;
    case (state_r)
      IDLE: begin
        if (ld) begin
          state_s = IDLE;
        end else if (start) begin
          state_s = (count != {CNT_W{1'b0}}) ? RUN : DONE;
        end else begin
          state_s = IDLE;
        end
      end
      RUN: begin
        if (rem_r == CNT_W'(1)) begin
          state_s = DONE;
        end else begin
          state_s = RUN;
        end
      end
      DONE:    state_s = IDLE;
      default: state_s = IDLE;
    endcase
  end

  // Output decode of the controller state.
  always_comb begin
    busy_s = 1'b0;
    done_s = 1'b0;
    case (state_r)
      RUN:     busy_s = 1'b1;
      DONE:    done_s = 1'b1;
      default: begin
        busy_s = 1'b0;
        done_s = 1'b0;
      end
    endcase
  end

  // Datapath next values; a burst uses the latched mode but live serial_in.
  always_comb begin
    out_s  = out_r;
    sout_s = sout_r;
    rem_s  = rem_r;
    mode_s = mode_r;
    step_s = {sout_r, out_r};
    case (state_r)
      IDLE: begin
        if (ld) begin
          out_s = in;
        end else if (start) begin
          mode_s = mode;
          rem_s  = count;
        end else if (shift) begin
          step_s = shift_step(out_r, mode, serial_in, sout_r);
          out_s  = step_s[WIDTH-1:0];
          sout_s = step_s[WIDTH];
        end else begin
          out_s = out_r;
        end
      end
      RUN: begin
        step_s = shift_step(out_r, mode_r, serial_in, sout_r);
        out_s  = step_s[WIDTH-1:0];
        sout_s = step_s[WIDTH];
        rem_s  = rem_r - CNT_W'(1);
      end
      default: begin
        out_s = out_r;
      end
    endcase
  end

  // Datapath registers.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      out_r  <= {WIDTH{1'b0}};
      sout_r <= 1'b0;
      rem_r  <= {CNT_W{1'b0}};
      mode_r <= 3'b000;
    end else begin
      out_r  <= out_s;
      sout_r <= sout_s;
      rem_r  <= rem_s;
      mode_r <= mode_s;
    end
  end

  assign out        = out_r;
  assign serial_out = sout_r;
  assign busy       = busy_s;
  assign done       = done_s;

endmodule
